// File: rtl/item_cfg_pkg.sv
// Shared definitions for the item table: word field layout, vend FSM states and fixed values.
// Used by item_cfg_mem and its storage sub-module.
package item_cfg_pkg;

    localparam int WORD_W    = 32;
    localparam int PRICE_LSB = 0;
    localparam int PRICE_W   = 16;
    localparam int STOCK_LSB = 16;
    localparam int STOCK_W   = 8;
    localparam int RSVD_LSB  = 24;
    localparam int RSVD_W    = 8;

    localparam logic [WORD_W-1:0]  OOR_READ_WORD = '0;
    localparam logic [STOCK_W-1:0] STOCK_EMPTY   = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_CHK,
        ST_WR,
        ST_RESP
    } vend_state_t;

    function automatic logic [PRICE_W-1:0] get_price(input logic [WORD_W-1:0] w);
        return w[PRICE_LSB +: PRICE_W];
    endfunction

    function automatic logic [STOCK_W-1:0] get_stock(input logic [WORD_W-1:0] w);
        return w[STOCK_LSB +: STOCK_W];
    endfunction

    // Price and reserved bits pass through untouched; only the stock field moves.
    function automatic logic [WORD_W-1:0] dec_stock(input logic [WORD_W-1:0] w);
        logic [STOCK_W-1:0] s;
        s = w[STOCK_LSB +: STOCK_W] - STOCK_W'(1);
        return {w[RSVD_LSB +: RSVD_W], s, w[PRICE_LSB +: PRICE_W]};
    endfunction

endpackage

// File: rtl/item_cfg_mem_if.sv
// Config read/write and vend request/response signals of item_cfg_mem.
// slave = the item table, master = whoever drives config and vend requests.
interface item_cfg_mem_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  cfg_read_en;
    logic [ADDR_WIDTH-1:0] cfg_read_addr;
    logic [31:0]           cfg_read_data;
    logic                  cfg_read_valid;
    logic                  cfg_write_en;
    logic [ADDR_WIDTH-1:0] cfg_write_addr;
    logic [31:0]           cfg_write_data;
    logic                  vend_req;
    logic [ADDR_WIDTH-1:0] vend_addr;
    logic                  vend_busy;
    logic                  vend_ack;
    logic                  vend_ok;
    logic [15:0]           vend_price;
    logic [7:0]            vend_stock;
    logic                  parity_err;

    modport slave (
        input  cfg_read_en, cfg_read_addr, cfg_write_en, cfg_write_addr, cfg_write_data,
               vend_req, vend_addr,
        output cfg_read_data, cfg_read_valid, vend_busy, vend_ack, vend_ok,
               vend_price, vend_stock, parity_err
    );

    modport master (
        output cfg_read_en, cfg_read_addr, cfg_write_en, cfg_write_addr, cfg_write_data,
               vend_req, vend_addr,
        input  cfg_read_data, cfg_read_valid, vend_busy, vend_ack, vend_ok,
               vend_price, vend_stock, parity_err
    );
endinterface

// File: rtl/item_mem_1r1w.sv
// Synchronous 1R1W item array, registered read, read-before-write on address collision.
// ITEM_MEM_PARITY_EN adds an even-parity bit per word and flags mismatches on the read output.
module item_mem_1r1w #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_perr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);
`ifdef ITEM_MEM_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    logic [SW-1:0] mem [DEPTH];
    logic [SW-1:0] q_reg;
    logic [SW-1:0] store_word;

`ifdef ITEM_MEM_PARITY_EN
    assign store_word = {^wr_data, wr_data};
    assign rd_perr    = ^q_reg;
`else
    assign store_word = wr_data;
    assign rd_perr    = 1'b0;
`endif
    assign rd_data = q_reg[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= store_word;
        end
        if (rd_en) begin
            q_reg <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/item_cfg_mem.sv
// Item table: fixed-latency config read/write port plus an atomic read-check-decrement vend FSM.
// Define ITEM_MEM_PARITY_EN to store and check a parity bit per item word.
module item_cfg_mem
    import item_cfg_pkg::*;
#(
    parameter int MAX_ITEMS  = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic         clk_fsm,
    input  logic         rstn,
    item_cfg_mem_if.slave bus
);

    vend_state_t           state_reg, state_next;
    logic [ADDR_WIDTH-1:0] vend_addr_reg;
    logic [WORD_W-1:0]     vend_word_reg;
    logic                  vend_perr_reg;
    logic                  rd_oor_reg;
    logic                  cfg_p1_reg;
    logic                  cfg_read_valid_reg;
    logic [WORD_W-1:0]     cfg_read_data_reg;
    logic                  cfg_perr_reg;
    logic                  vend_ok_reg;
    logic [PRICE_W-1:0]    vend_price_reg;
    logic [STOCK_W-1:0]    vend_stock_reg;

    logic                  rd_req, vend_rd, vend_wr, hazard;
    logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
    logic [WORD_W-1:0]     wr_data, mem_rd_data, rd_word;
    logic                  mem_rd_perr, rd_perr, mem_rd_en, mem_wr_en;
    logic                  resp_load, resp_ok;
    logic [STOCK_W-1:0]    resp_stock;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < MAX_ITEMS;
    endfunction

    // Config traffic owns each port whenever it is active; the FSM only fills idle slots.
    assign vend_rd   = (state_reg == ST_RD) && !bus.cfg_read_en;
    assign vend_wr   = (state_reg == ST_WR) && !bus.cfg_write_en;
    assign hazard    = bus.cfg_write_en && (bus.cfg_write_addr == vend_addr_reg);
    assign rd_req    = bus.cfg_read_en || vend_rd;
    assign rd_addr   = bus.cfg_read_en ? bus.cfg_read_addr : vend_addr_reg;
    assign mem_rd_en = rd_req && in_range(rd_addr);
    assign wr_addr   = bus.cfg_write_en ? bus.cfg_write_addr : vend_addr_reg;
    assign wr_data   = bus.cfg_write_en ? bus.cfg_write_data : dec_stock(vend_word_reg);
    assign mem_wr_en = bus.cfg_write_en ? in_range(bus.cfg_write_addr) : vend_wr;
    assign rd_word   = rd_oor_reg ? OOR_READ_WORD : mem_rd_data;
    assign rd_perr   = !rd_oor_reg && mem_rd_perr;

    item_mem_1r1w #(
        .WIDTH (WORD_W),
        .DEPTH (MAX_ITEMS),
        .AW    (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk_fsm),
        .rd_en   (mem_rd_en),
        .rd_addr (rd_addr),
        .rd_data (mem_rd_data),
        .rd_perr (mem_rd_perr),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    // Any config write to the latched item between read issue and our own write
    // invalidates the fetched word, so the FSM goes back and re-reads it.
    always_comb begin
        state_next = state_reg;
        resp_load  = 1'b0;
        resp_ok    = 1'b0;
        resp_stock = STOCK_EMPTY;
        case (state_reg)
            ST_IDLE: if (bus.vend_req) state_next = ST_RD;
            ST_RD:   if (!hazard && !bus.cfg_read_en) state_next = ST_WAIT;
            ST_WAIT: state_next = hazard ? ST_RD : ST_CHK;
            ST_CHK: begin
                if (hazard) begin
                    state_next = ST_RD;
                end else if (vend_perr_reg || get_stock(vend_word_reg) == STOCK_EMPTY) begin
                    state_next = ST_RESP;
                    resp_load  = 1'b1;
                    resp_stock = get_stock(vend_word_reg);
                end else begin
                    state_next = ST_WR;
                end
            end
            ST_WR: begin
                if (!bus.cfg_write_en) begin
                    state_next = ST_RESP;
                    resp_load  = 1'b1;
                    resp_ok    = 1'b1;
                    resp_stock = get_stock(dec_stock(vend_word_reg));
                end else if (hazard) begin
                    state_next = ST_RD;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_fsm) begin
        if (!rstn) begin
            state_reg          <= ST_IDLE;
            vend_addr_reg      <= '0;
            vend_word_reg      <= '0;
            vend_perr_reg      <= 1'b0;
            rd_oor_reg         <= 1'b0;
            cfg_p1_reg         <= 1'b0;
            cfg_read_valid_reg <= 1'b0;
            cfg_read_data_reg  <= '0;
            cfg_perr_reg       <= 1'b0;
            vend_ok_reg        <= 1'b0;
            vend_price_reg     <= '0;
            vend_stock_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && bus.vend_req) begin
                vend_addr_reg <= bus.vend_addr;
            end
            if (state_reg == ST_WAIT) begin
                vend_word_reg <= rd_word;
                vend_perr_reg <= rd_perr;
            end
            if (rd_req) begin
                rd_oor_reg <= !in_range(rd_addr);
            end
            cfg_p1_reg         <= bus.cfg_read_en;
            cfg_read_valid_reg <= cfg_p1_reg;
            cfg_perr_reg       <= cfg_p1_reg && rd_perr;
            if (cfg_p1_reg) begin
                cfg_read_data_reg <= rd_word;
            end
            if (resp_load) begin
                vend_ok_reg    <= resp_ok;
                vend_price_reg <= get_price(vend_word_reg);
                vend_stock_reg <= resp_stock;
            end
        end
    end

    assign bus.cfg_read_data  = cfg_read_data_reg;
    assign bus.cfg_read_valid = cfg_read_valid_reg;
    assign bus.vend_busy      = (state_reg != ST_IDLE);
    assign bus.vend_ack       = (state_reg == ST_RESP);
    assign bus.vend_ok        = vend_ok_reg;
    assign bus.vend_price     = vend_price_reg;
    assign bus.vend_stock     = vend_stock_reg;
    assign bus.parity_err     = cfg_perr_reg || (state_reg == ST_CHK && vend_perr_reg);

endmodule
